count_display_driver: RTL and testbench
=======================================

// Module: count_display_driver
// PURPOSE
// - Downstream consumer of the 8-bit counter output (uo_out); shows the count in decimal on a 3-digit multiplexed 7-segment display.
// - Takes a binary value via a valid/ready handshake and converts it to BCD with an iterative double-dabble (one bit per cycle).
// - Commits the 3 BCD digits to display registers and continuously scans them with a prescaled one-hot digit select.
// PARAMETERS
// - SCAN_DIV  1000  clk cycles each digit stays active; legal range >= 2; scan counter width $clog2(SCAN_DIV)
// PORTS
// - clk          input   1  single clock, all state on rising edge
// - rst          input   1  synchronous reset, active-high
// - value        input   8  binary count to display (0..255)
// - value_valid  input   1  value present; accepted when value_valid && value_ready
// - value_ready  output  1  block can accept a value (high only in IDLE)
// - busy         output  1  conversion in progress (SHIFT or COMMIT)
// - seg          output  7  segments {g,f,e,d,c,b,a}, active-high, combinational decode of selected digit
// - digit_sel    output  3  one-hot digit enable, bit0=ones, bit1=tens, bit2=hundreds, active-high
// BEHAVIOUR
// - Reset (rst high at a rising edge): state=IDLE, value_ready=1, busy=0, display digits hundreds/tens/ones=0,
//   scan_cnt=0, digit_sel=3'b001, seg=7'h3F ("0"); any conversion in flight is discarded, display not updated.
// - FSM: IDLE -> SHIFT on accept; SHIFT runs exactly 8 cycles (bit_cnt 7..0) -> COMMIT; COMMIT 1 cycle -> IDLE.
// - Accept edge: value captured into shift reg, 12-bit BCD scratch cleared, bit_cnt=7.
// - SHIFT cycle: each BCD nibble >= 5 gets +3, then {bcd,shift} shifted left 1; BCD nibbles never exceed 9 after finish.
// - COMMIT edge: scratch BCD copied to display digits; visible on seg from the following cycle.
// - Latency: value accepted at edge N -> display digits updated at edge N+9; value_ready high again after edge N+9.
// - value_valid while busy: ignored, not queued; value_ready=0. Held valid is accepted on first IDLE cycle after COMMIT.
// - Valid asserted in same cycle as rst: rst wins, nothing accepted.
// - Scan: scan_cnt increments every cycle independent of FSM; at SCAN_DIV-1 it wraps to 0 and digit_sel rotates
//   001->010->100->001 on that same edge. Scan never stalls during conversion; display shows old digits until COMMIT.
// - seg decode: digits 0-9 standard patterns (0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F); any other code -> 7'h00.
// - Arithmetic: BCD add-3 per nibble is 4-bit, no carry between nibbles; hundreds nibble max 2.
// CONFIGURATION
// - LEADING_ZERO_BLANK_EN defined: seg=7'h00 when hundreds selected and hundreds==0, and when tens selected and
//   hundreds==0 and tens==0; ones digit never blanked (value 0 shows "  0"). digit_sel timing unchanged.
// - LEADING_ZERO_BLANK_EN undefined: all three digits always decoded (value 7 shows "007").
// TESTING
// - Reset: hold rst 2 cycles -> value_ready=1, busy=0, digit_sel=001, seg=7'h3F; SCAN_DIV=4: digit_sel 010 after 4 cycles, 100 after 8, 001 after 12.
// - value=123, valid 1 cycle -> busy high 9 cycles, digits 1/2/3; seg=06 on 100, 5B on 010, 4F on 001.
// - value=255 then 0 back-to-back (valid held) -> 2/5/5 committed at N+9, second accept at edge N+10 (first IDLE cycle after COMMIT), 0/0/0 at N+19.
// - Valid pulsed with value=99 during SHIFT of value=200 -> 99 ignored, display 2/0/0, value_ready low throughout.
// - rst asserted at 4th SHIFT cycle of value=88 -> display 0/0/0, IDLE next cycle, no COMMIT.
// - LEADING_ZERO_BLANK_EN, value=7 -> seg 00 on hundreds, 00 on tens, 07 on ones; value=40 -> 00, 66, 3F.

Source files
------------

// File: rtl/count_display_driver.sv
// Binary-to-decimal driver for a 3-digit multiplexed 7-segment display: iterative double-dabble
// conversion behind a valid/ready handshake, plus a free-running prescaled digit scan.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading zero hundreds/tens digits).
module count_display_driver #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       value_valid,
    output logic       value_ready,
    output logic       busy,
    output logic [6:0] seg,
    output logic [2:0] digit_sel
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state_reg;
    logic        value_ready_reg;
    logic        busy_reg;
    logic [7:0]  shift_reg;
    logic [11:0] bcd_reg;
    logic [2:0]  bit_cnt_reg;
    logic [3:0]  hundreds_reg;
    logic [3:0]  tens_reg;
    logic [3:0]  ones_reg;

    logic [SCAN_W-1:0] scan_cnt_reg;
    logic [2:0]        digit_sel_reg;

    // Add-3 correction for the ones and tens nibbles. The hundreds nibble of an
    // 8-bit input never reaches 5 before a shift, so it needs no correction.
    logic [7:0] bcd_adj;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            value_ready_reg <= 1'b1;
            busy_reg        <= 1'b0;
            shift_reg       <= '0;
            bcd_reg         <= '0;
            bit_cnt_reg     <= '0;
            hundreds_reg    <= '0;
            tens_reg        <= '0;
            ones_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (value_valid) begin
                        shift_reg       <= value;
                        bcd_reg         <= '0;
                        bit_cnt_reg     <= 3'd7;
                        state_reg       <= SHIFT;
                        value_ready_reg <= 1'b0;
                        busy_reg        <= 1'b1;
                    end
                end
                SHIFT: begin
                    // {bcd, shift} <<= 1 after nibble correction
                    bcd_reg   <= {bcd_reg[10:8], bcd_adj, shift_reg[7]};
                    shift_reg <= {shift_reg[6:0], 1'b0};
                    if (bit_cnt_reg == 3'd0) begin
                        state_reg <= COMMIT;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg - 3'd1;
                    end
                end
                COMMIT: begin
                    hundreds_reg    <= bcd_reg[11:8];
                    tens_reg        <= bcd_reg[7:4];
                    ones_reg        <= bcd_reg[3:0];
                    state_reg       <= IDLE;
                    value_ready_reg <= 1'b1;
                    busy_reg        <= 1'b0;
                end
                default: begin
                    state_reg       <= IDLE;
                    value_ready_reg <= 1'b1;
                    busy_reg        <= 1'b0;
                end
            endcase
        end
    end

    // Scan runs regardless of conversion activity; old digits stay visible until COMMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_reg  <= '0;
            digit_sel_reg <= 3'b001;
        end else if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg  <= '0;
            digit_sel_reg <= {digit_sel_reg[1:0], digit_sel_reg[2]};
        end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
    end

    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [3:0] sel_digit;
    logic       blank;

    always_comb begin
        sel_digit = 4'hF;
        case (digit_sel_reg)
            3'b001:  sel_digit = ones_reg;
            3'b010:  sel_digit = tens_reg;
            3'b100:  sel_digit = hundreds_reg;
            default: sel_digit = 4'hF;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        blank = (digit_sel_reg[2] && (hundreds_reg == 4'd0))
             || (digit_sel_reg[1] && (hundreds_reg == 4'd0) && (tens_reg == 4'd0));
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    assign seg         = blank ? 7'h00 : decode_digit(sel_digit);
    assign digit_sel   = digit_sel_reg;
    assign value_ready = value_ready_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench for count_display_driver: expected values queued at drive time,
// popped and compared against the scanned display once a conversion commits.
module tb_count_display_driver;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] value;
    logic       value_valid;
    logic       value_ready;
    logic       busy;
    logic [6:0] seg;
    logic [2:0] digit_sel;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    count_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .busy        (busy),
        .seg         (seg),
        .digit_sel   (digit_sel)
    );

    function automatic logic [6:0] seg_pat(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // pos: 0 = ones, 1 = tens, 2 = hundreds
    function automatic logic [6:0] exp_seg(input int v, input int pos);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos == 2 && h == 0) return 7'h00;
        if (pos == 1 && h == 0 && t == 0) return 7'h00;
`endif
        if (pos == 2) return seg_pat(h);
        if (pos == 1) return seg_pat(t);
        return seg_pat(o);
    endfunction

    // Records the first seg value seen for each digit position, starting at the current negedge.
    task automatic capture(output logic [6:0] s_o, output logic [6:0] s_t,
                           output logic [6:0] s_h, output bit ok);
        bit seen_o, seen_t, seen_h;
        seen_o = 0; seen_t = 0; seen_h = 0;
        s_o = '0; s_t = '0; s_h = '0;
        for (int i = 0; i < 16 && !(seen_o && seen_t && seen_h); i++) begin
            case (digit_sel)
                3'b001: if (!seen_o) begin s_o = seg; seen_o = 1; end
                3'b010: if (!seen_t) begin s_t = seg; seen_t = 1; end
                3'b100: if (!seen_h) begin s_h = seg; seen_h = 1; end
                default: ;
            endcase
            @(negedge clk);
        end
        ok = seen_o && seen_t && seen_h;
    endtask

    // Waits (bounded) until busy drops; counts busy negedges including the current one.
    task automatic wait_idle(output int busy_cycles, output bit ready_bad, output bit ok);
        busy_cycles = 0;
        ready_bad   = 0;
        ok          = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            busy_cycles++;
            if (value_ready) ready_bad = 1;
            @(negedge clk);
        end
    endtask

    task automatic drive_one(input int v);
        value       = 8'(v);
        value_valid = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; value = 8'd55; value_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; value_valid = 1'b0;
        n_checks++; if (value_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", value_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (digit_sel !== 3'b001) begin n_fail++; $display("FAIL reset_sel: got %b expected 001", digit_sel); end
        n_checks++; if (seg !== 7'h3F) begin n_fail++; $display("FAIL reset_seg: got %h expected 3f", seg); end
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 4) begin
                n_checks++; if (digit_sel !== 3'b010) begin n_fail++; $display("FAIL scan_4: got %b expected 010", digit_sel); end
            end else if (i == 8) begin
                n_checks++; if (digit_sel !== 3'b100) begin n_fail++; $display("FAIL scan_8: got %b expected 100", digit_sel); end
            end else if (i == 12) begin
                n_checks++; if (digit_sel !== 3'b001) begin n_fail++; $display("FAIL scan_12: got %b expected 001", digit_sel); end
            end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_valid_ignored: busy got %b expected 0", busy); end
        $display("reset: rst held 2 cycles, scan rotation checked");
    endtask

    task automatic test_basic;
        int cyc; bit rbad, ok; int v;
        logic [6:0] s_o, s_t, s_h;
        drive_one(123);
        n_checks++; if (busy !== 1'b1 || value_ready !== 1'b0) begin n_fail++; $display("FAIL basic_accept: busy/ready got %b%b expected 10", busy, value_ready); end
        wait_idle(cyc, rbad, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: busy stuck, got 1 expected 0"); end
        n_checks++; if (cyc != 9) begin n_fail++; $display("FAIL basic_busy_len: got %0d expected 9", cyc); end
        n_checks++; if (rbad) begin n_fail++; $display("FAIL basic_ready_while_busy: got 1 expected 0"); end
        v = exp_q.pop_front();
        capture(s_o, s_t, s_h, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_scan: digits not all seen, got 0 expected 1"); end
        n_checks++; if (s_h !== exp_seg(v, 2)) begin n_fail++; $display("FAIL basic_hundreds: got %h expected %h", s_h, exp_seg(v, 2)); end
        n_checks++; if (s_t !== exp_seg(v, 1)) begin n_fail++; $display("FAIL basic_tens: got %h expected %h", s_t, exp_seg(v, 1)); end
        n_checks++; if (s_o !== exp_seg(v, 0)) begin n_fail++; $display("FAIL basic_ones: got %h expected %h", s_o, exp_seg(v, 0)); end
        $display("basic: value=%0d segs h=%h t=%h o=%h busy_cycles=%0d", v, s_h, s_t, s_o, cyc);
    endtask

    task automatic test_back_to_back;
        int cyc; bit rbad, ok; int v;
        logic [6:0] s_o, s_t, s_h;
        value = 8'd255; value_valid = 1'b1; exp_q.push_back(255);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_first_accept: got %b expected 1", busy); end
        value = 8'd0; exp_q.push_back(0);
        wait_idle(cyc, rbad, ok);
        n_checks++; if (cyc != 9 || !ok) begin n_fail++; $display("FAIL b2b_first_len: got %0d expected 9", cyc); end
        n_checks++; if (value_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_gap: got %b expected 1", value_ready); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: got %b expected 1", busy); end
        value_valid = 1'b0;
        v = exp_q.pop_front();
        capture(s_o, s_t, s_h, ok);
        n_checks++; if (!ok || s_h !== exp_seg(v, 2) || s_t !== exp_seg(v, 1) || s_o !== exp_seg(v, 0)) begin
            n_fail++; $display("FAIL b2b_first_display: got %h_%h_%h expected %h_%h_%h", s_h, s_t, s_o, exp_seg(v, 2), exp_seg(v, 1), exp_seg(v, 0));
        end
        $display("b2b: value=%0d segs h=%h t=%h o=%h", v, s_h, s_t, s_o);
        wait_idle(cyc, rbad, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_second_timeout: busy got 1 expected 0"); end
        v = exp_q.pop_front();
        capture(s_o, s_t, s_h, ok);
        n_checks++; if (!ok || s_h !== exp_seg(v, 2) || s_t !== exp_seg(v, 1) || s_o !== exp_seg(v, 0)) begin
            n_fail++; $display("FAIL b2b_second_display: got %h_%h_%h expected %h_%h_%h", s_h, s_t, s_o, exp_seg(v, 2), exp_seg(v, 1), exp_seg(v, 0));
        end
        $display("b2b: value=%0d segs h=%h t=%h o=%h", v, s_h, s_t, s_o);
    endtask

    task automatic test_ignore_busy;
        int cyc; bit rbad, ok; int v; bit extra;
        logic [6:0] s_o, s_t, s_h;
        drive_one(200);
        @(negedge clk);
        @(negedge clk);
        value = 8'd99; value_valid = 1'b1;
        n_checks++; if (value_ready !== 1'b0) begin n_fail++; $display("FAIL ignore_ready: got %b expected 0", value_ready); end
        @(negedge clk);
        value_valid = 1'b0; value = 8'd0;
        wait_idle(cyc, rbad, ok);
        n_checks++; if (!ok || rbad) begin n_fail++; $display("FAIL ignore_ready_low: ready_high_while_busy=%b idle=%b expected 0 and 1", rbad, ok); end
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy) extra = 1;
        end
        n_checks++; if (extra) begin n_fail++; $display("FAIL ignore_not_queued: busy got 1 expected 0"); end
        v = exp_q.pop_front();
        capture(s_o, s_t, s_h, ok);
        n_checks++; if (!ok || s_h !== exp_seg(v, 2) || s_t !== exp_seg(v, 1) || s_o !== exp_seg(v, 0)) begin
            n_fail++; $display("FAIL ignore_display: got %h_%h_%h expected %h_%h_%h", s_h, s_t, s_o, exp_seg(v, 2), exp_seg(v, 1), exp_seg(v, 0));
        end
        $display("ignore: value=%0d segs h=%h t=%h o=%h", v, s_h, s_t, s_o);
    endtask

    task automatic test_reset_mid;
        bit ok; int v; bit extra;
        logic [6:0] s_o, s_t, s_h;
        value = 8'd88; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_accept: got %b expected 1", busy); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || value_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_idle: busy/ready got %b%b expected 01", busy, value_ready); end
        exp_q.delete();
        exp_q.push_back(0);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) extra = 1;
        end
        n_checks++; if (extra) begin n_fail++; $display("FAIL rmid_no_commit: busy got 1 expected 0"); end
        v = exp_q.pop_front();
        capture(s_o, s_t, s_h, ok);
        n_checks++; if (!ok || s_h !== exp_seg(v, 2) || s_t !== exp_seg(v, 1) || s_o !== exp_seg(v, 0)) begin
            n_fail++; $display("FAIL rmid_display: got %h_%h_%h expected %h_%h_%h", s_h, s_t, s_o, exp_seg(v, 2), exp_seg(v, 1), exp_seg(v, 0));
        end
        $display("reset_mid: display after abort h=%h t=%h o=%h", s_h, s_t, s_o);
    endtask

    task automatic test_sweep;
        int vals[9] = '{0, 7, 9, 10, 40, 99, 100, 199, 255};
        int cyc; bit rbad, ok; int v;
        logic [6:0] s_o, s_t, s_h;
        for (int k = 0; k < 9; k++) begin
            drive_one(vals[k]);
            wait_idle(cyc, rbad, ok);
            n_checks++; if (!ok || cyc != 9) begin n_fail++; $display("FAIL sweep_len_%0d: got %0d expected 9", vals[k], cyc); end
            v = exp_q.pop_front();
            capture(s_o, s_t, s_h, ok);
            n_checks++; if (!ok || s_h !== exp_seg(v, 2) || s_t !== exp_seg(v, 1) || s_o !== exp_seg(v, 0)) begin
                n_fail++; $display("FAIL sweep_display_%0d: got %h_%h_%h expected %h_%h_%h", v, s_h, s_t, s_o, exp_seg(v, 2), exp_seg(v, 1), exp_seg(v, 0));
            end
            $display("sweep: value=%0d segs h=%h t=%h o=%h", v, s_h, s_t, s_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; value = '0; value_valid = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
